dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single data-memory port between two requesters: the CPU load/store path (port C) and the program/data loader (port L). Each requester uses a req/ack handshake. The arbiter grants one request at a time and drives the memory strobe for exactly one cycle. It then returns read data together with a one-cycle ack. It sits between the CPU's MemOrIO address/data path and DMem, and the CPU stalls on `c_stall` while its access is pending.

## Interface
- `AW`, 14, word-address width.
- `DW`, 32, data width.
- `DEPTH`, 16384, number of implemented words. Addresses `>= DEPTH` are out of range.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `c_req`  in  1  CPU request.
- `c_we`  in  1  CPU write (1) / read (0).
- `c_addr`  in  AW  CPU word address.
- `c_wdata`  in  DW  CPU write data.
- `c_ack`  out  1  CPU transaction complete, one-cycle pulse.
- `c_rdata`  out  DW  CPU read data, valid when `c_ack`=1.
- `c_stall`  out  1  `c_req & ~c_ack`, combinational.
- `l_req`, `l_we`, `l_addr`, `l_wdata`, `l_ack`, `l_rdata`  same as the CPU set, for the loader.
- `err`  out  1  one-cycle pulse with the ack of an out-of-range access.
- `mem_en`  out  1  memory strobe.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  DW  memory write data.
- `mem_rdata`  in  DW  memory read data, one-cycle synchronous latency.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant round-robin. The port that was not granted last wins.
  - On grant: latch `we`, `addr`, `wdata` and the owner into internal registers, then go to ACCESS.
- Requester inputs are sampled only at grant. Requester rule: hold `req` high until its ack is seen, and drop it in the cycle after the ack.
- ACCESS, normal (`addr < DEPTH`):
  - Drive `mem_en`=1, `mem_we` = latched `we`, and latched `addr`/`wdata` for exactly this cycle.
  - Go to DONE.
- ACCESS, out of range (`addr >= DEPTH`):
  - `mem_en` stays 0 and no memory write occurs.
  - Go to DONE with the error flag set.
- DONE:
  - Pulse the owner's ack.
  - Owner's rdata is `mem_rdata` for a normal read, 0 for a write or an out-of-range access.
  - `err` pulses if the error flag is set.
  - Update the last-grant pointer, then go to IDLE.
- `x_rdata` is registered and holds its value until the next ack to that port.
- The non-owner ack is always 0. A request that arrives during ACCESS or DONE waits in IDLE.
- Reset mid-transaction (async):
  - State goes to IDLE, all acks/`err`/`mem_en`/`mem_we` go to 0 immediately.
  - The pending access is abandoned with no ack; the requester must re-request.
  - A memory write is lost if reset asserts during ACCESS.

## Timing
- Reset values:
  - State IDLE.
  - `c_ack`=`l_ack`=`err`=`mem_en`=`mem_we`=0.
  - `mem_addr`=0, `mem_wdata`=0, `c_rdata`=`l_rdata`=0.
  - Last-grant = L, so the CPU wins the first tie.
- Latency: request seen at edge k (in IDLE) gives ACCESS in cycle k+1 and ack in cycle k+2.
- Throughput: three cycles per transaction; the earliest next grant is at the edge after DONE.
- `mem_*` outputs are registered. `c_stall` is the only combinational output.
- A request still high in IDLE after its ack is treated as a new transaction.

## Configuration
- `ARB_CPU_PRIORITY_EN`:
  - Defined: fixed priority. The CPU always wins a tie and the last-grant pointer is unused; the loader can starve while `c_req` is held.
  - Undefined: round-robin as above.

## Test plan
- CPU write then read: `c_req`, `c_we`=1, `c_addr`=0x010, `c_wdata`=0xDEADBEEF.
  - Required: `mem_en`=`mem_we`=1 in cycle k+1, `c_ack` in k+2, `c_stall` high for 2 cycles.
  - Follow-up read of 0x010: `c_rdata`=0xDEADBEEF with `c_ack`.
- Simultaneous requests from reset: CPU read 0x001, loader write 0x002←0x5A.
  - Required: CPU acked first, then loader at least 3 cycles later.
  - Second simultaneous pair: loader granted first (round-robin).
  - With `ARB_CPU_PRIORITY_EN`: CPU granted first in both pairs.
- Out of range: loader write with `l_addr` = `DEPTH`.
  - Required: `mem_en` stays 0, `l_ack` and `err` pulse together, `l_rdata`=0, memory unchanged.
- Held request: CPU keeps `c_req` high for 8 cycles.
  - Required: two acks, at cycles k+2 and k+5, and two memory strobes.
- Reset during ACCESS of a CPU write to 0x020.
  - Required: outputs 0 asynchronously, no `c_ack`, FSM in IDLE after release.
  - A new CPU request completes normally.
- Loader-only burst: writes to 0x000..0x003.
  - Required: acks every 3 cycles, all four words read back correctly.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port (CPU / loader) arbiter for the single data-memory port: IDLE -> ACCESS -> DONE per transaction.
// Optional macro ARB_CPU_PRIORITY_EN selects fixed CPU priority instead of round-robin on ties.
module dmem_arbiter #(
    parameter int AW    = 14,
    parameter int DW    = 32,
    parameter int DEPTH = 16384
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          c_req_i,
    input  logic          c_we_i,
    input  logic [AW-1:0] c_addr_i,
    input  logic [DW-1:0] c_wdata_i,
    output logic          c_ack_o,
    output logic [DW-1:0] c_rdata_o,
    output logic          c_stall_o,
    input  logic          l_req_i,
    input  logic          l_we_i,
    input  logic [AW-1:0] l_addr_i,
    input  logic [DW-1:0] l_wdata_i,
    output logic          l_ack_o,
    output logic [DW-1:0] l_rdata_o,
    output logic          err_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [AW:0] DEPTH_LIM = DEPTH[AW:0];
    localparam logic        OWN_C     = 1'b0;
    localparam logic        OWN_L     = 1'b1;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic          oor_q, oor_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          c_ack_q, c_ack_d;
    logic          l_ack_q, l_ack_d;
    logic          err_q, err_d;
    logic [DW-1:0] c_rdata_q, c_rdata_d;
    logic [DW-1:0] l_rdata_q, l_rdata_d;
`ifndef ARB_CPU_PRIORITY_EN
    logic          last_q, last_d;
`endif

    logic          grant_c, grant_l, grant;
    logic          sel_we, sel_oor;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic [DW-1:0] done_rdata;

    assign grant     = grant_c | grant_l;
    assign sel_we    = grant_l ? l_we_i    : c_we_i;
    assign sel_addr  = grant_l ? l_addr_i  : c_addr_i;
    assign sel_wdata = grant_l ? l_wdata_i : c_wdata_i;
    assign sel_oor   = ({1'b0, sel_addr} >= DEPTH_LIM);

    // State register and all registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_C;
            we_q        <= 1'b0;
            oor_q       <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            c_ack_q     <= 1'b0;
            l_ack_q     <= 1'b0;
            err_q       <= 1'b0;
            c_rdata_q   <= '0;
            l_rdata_q   <= '0;
`ifndef ARB_CPU_PRIORITY_EN
            last_q      <= OWN_L;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            oor_q       <= oor_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            c_ack_q     <= c_ack_d;
            l_ack_q     <= l_ack_d;
            err_q       <= err_d;
            c_rdata_q   <= c_rdata_d;
            l_rdata_q   <= l_rdata_d;
`ifndef ARB_CPU_PRIORITY_EN
            last_q      <= last_d;
`endif
        end
    end

    // Next-state and grant decision.
    always_comb begin
        state_d = state_q;
        grant_c = 1'b0;
        grant_l = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (c_req_i && l_req_i) begin
`ifdef ARB_CPU_PRIORITY_EN
                    grant_c = 1'b1;
`else
                    grant_c = (last_q == OWN_L);
                    grant_l = (last_q == OWN_C);
`endif
                end else begin
                    grant_c = c_req_i;
                    grant_l = l_req_i;
                end
                if (grant_c || grant_l) state_d = ST_ACCESS;
            end
            ST_ACCESS: state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Memory read data arrives during DONE, so it bypasses into rdata for the ack cycle.
    assign done_rdata = (!we_q && !oor_q) ? mem_rdata_i : '0;

    // Output / datapath next values.
    always_comb begin
        owner_d     = owner_q;
        we_d        = we_q;
        oor_d       = oor_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_en_d    = grant & ~sel_oor;
        mem_we_d    = grant & sel_we & ~sel_oor;
        if (grant) begin
            owner_d     = grant_l ? OWN_L : OWN_C;
            we_d        = sel_we;
            oor_d       = sel_oor;
            mem_addr_d  = sel_addr;
            mem_wdata_d = sel_wdata;
        end
        c_ack_d   = (state_q == ST_ACCESS) && (owner_q == OWN_C);
        l_ack_d   = (state_q == ST_ACCESS) && (owner_q == OWN_L);
        err_d     = (state_q == ST_ACCESS) && oor_q;
        c_rdata_d = c_ack_q ? done_rdata : c_rdata_q;
        l_rdata_d = l_ack_q ? done_rdata : l_rdata_q;
`ifndef ARB_CPU_PRIORITY_EN
        last_d    = (state_q == ST_DONE) ? owner_q : last_q;
`endif
    end

    assign c_ack_o     = c_ack_q;
    assign l_ack_o     = l_ack_q;
    assign err_o       = err_q;
    assign c_rdata_o   = c_ack_q ? done_rdata : c_rdata_q;
    assign l_rdata_o   = l_ack_q ? done_rdata : l_rdata_q;
    assign c_stall_o   = c_req_i & ~c_ack_q;
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a small synchronous memory model (DEPTH reduced to 256).
module tb_dmem_arbiter;
    localparam int AW    = 14;
    localparam int DW    = 32;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          c_req, c_we, l_req, l_we;
    logic [AW-1:0] c_addr, l_addr;
    logic [DW-1:0] c_wdata, l_wdata;
    logic          c_ack, l_ack, c_stall, err;
    logic [DW-1:0] c_rdata, l_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    dmem_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .c_req_i(c_req), .c_we_i(c_we), .c_addr_i(c_addr), .c_wdata_i(c_wdata),
        .c_ack_o(c_ack), .c_rdata_o(c_rdata), .c_stall_o(c_stall),
        .l_req_i(l_req), .l_we_i(l_we), .l_addr_i(l_addr), .l_wdata_i(l_wdata),
        .l_ack_o(l_ack), .l_rdata_o(l_rdata),
        .err_o(err), .mem_en_o(mem_en), .mem_we_o(mem_we),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: one-cycle synchronous read, cleared before the first test.
    logic [DW-1:0] mem [DEPTH];
    logic          mem_clr = 1'b1;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            mem_rdata <= '0;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
            mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    int strobes = 0;
    always @(posedge clk) if (mem_en) strobes++;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;
    exp_t c_q[$];
    exp_t l_q[$];

    // Monitor: pop and compare on every ack.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (c_ack) begin
                if (c_q.size() == 0) check("c_ack_unexpected", 1, 0);
                else begin
                    e = c_q.pop_front();
                    check("c_rdata", c_rdata, e.rdata);
                    check("c_err", err, e.err);
                    $display("txn C ack rdata=%08h err=%0b", c_rdata, err);
                end
            end
            if (l_ack) begin
                if (l_q.size() == 0) check("l_ack_unexpected", 1, 0);
                else begin
                    e = l_q.pop_front();
                    check("l_rdata", l_rdata, e.rdata);
                    check("l_err", err, e.err);
                    $display("txn L ack rdata=%08h err=%0b", l_rdata, err);
                end
            end
            if (c_ack && l_ack) check("both_acks", 1, 0);
            if (err && !(c_ack || l_ack)) check("err_without_ack", 1, 0);
        end
    end

    task automatic c_txn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [DW-1:0] exp_rd, input logic exp_err, output int lat);
        exp_t e;
        e.rdata = exp_rd; e.err = exp_err;
        c_q.push_back(e);
        c_req = 1'b1; c_we = we; c_addr = a; c_wdata = wd;
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!c_ack && lat < 20);
        if (!c_ack) check("c_timeout", 0, 1);
        @(posedge clk); #1;
        c_req = 1'b0; c_we = 1'b0;
    endtask

    task automatic l_txn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [DW-1:0] exp_rd, input logic exp_err, output int lat);
        exp_t e;
        e.rdata = exp_rd; e.err = exp_err;
        l_q.push_back(e);
        l_req = 1'b1; l_we = we; l_addr = a; l_wdata = wd;
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!l_ack && lat < 20);
        if (!l_ack) check("l_timeout", 0, 1);
        @(posedge clk); #1;
        l_req = 1'b0; l_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lc, ll, s0, n, t, seen;
        int ackt[4];
        exp_t e;
        rst_n = 1'b0;
        c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
        l_req = 0; l_we = 0; l_addr = '0; l_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_c_ack", c_ack, 0);
        check("rst_l_ack", l_ack, 0);
        check("rst_err", err, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_c_rdata", c_rdata, 0);
        check("rst_l_rdata", l_rdata, 0);
        mem_clr = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Simultaneous pair from reset: CPU wins.
        fork
            c_txn(1'b0, 14'h001, 32'h0, 32'h0, 1'b0, lc);
            l_txn(1'b1, 14'h002, 32'h5A, 32'h0, 1'b0, ll);
        join
        check("pair1_c_lat", lc, 2);
        check("pair1_l_lat", ll, 5);

        // CPU write with cycle-exact timing.
        c_req = 1'b1; c_we = 1'b1; c_addr = 14'h010; c_wdata = 32'hDEADBEEF;
        e.rdata = 32'h0; e.err = 1'b0;
        c_q.push_back(e);
        #1;
        check("wr_stall_k", c_stall, 1);
        @(posedge clk); #1;
        check("wr_mem_en_k1", mem_en, 1);
        check("wr_mem_we_k1", mem_we, 1);
        check("wr_mem_addr_k1", mem_addr, 14'h010);
        check("wr_mem_wdata_k1", mem_wdata, 32'hDEADBEEF);
        check("wr_stall_k1", c_stall, 1);
        check("wr_ack_k1", c_ack, 0);
        @(posedge clk); #1;
        check("wr_ack_k2", c_ack, 1);
        check("wr_stall_k2", c_stall, 0);
        check("wr_mem_en_k2", mem_en, 0);
        @(posedge clk); #1;
        c_req = 1'b0; c_we = 1'b0;
        c_txn(1'b0, 14'h010, 32'h0, 32'hDEADBEEF, 1'b0, lc);
        check("rd_lat", lc, 2);

        // Second simultaneous pair: last grant was CPU, so loader wins unless CPU priority.
        fork
            c_txn(1'b0, 14'h002, 32'h0, 32'h5A, 1'b0, lc);
            l_txn(1'b1, 14'h003, 32'h77, 32'h0, 1'b0, ll);
        join
`ifdef ARB_CPU_PRIORITY_EN
        check("pair2_c_lat", lc, 2);
        check("pair2_l_lat", ll, 5);
`else
        check("pair2_l_lat", ll, 2);
        check("pair2_c_lat", lc, 5);
`endif

        // Out-of-range loader write.
        s0 = strobes;
        l_txn(1'b1, AW'(DEPTH), 32'h00000BAD, 32'h0, 1'b1, ll);
        check("oor_strobes", strobes - s0, 0);
        check("oor_l_rdata_hold", l_rdata, 0);
        check("c_rdata_hold", c_rdata, 32'h5A);
        c_txn(1'b0, 14'h000, 32'h0, 32'h0, 1'b0, lc);

        // Held request: two back-to-back transactions.
        s0 = strobes;
        seen = 0;
        ackt[0] = 0; ackt[1] = 0;
        e.rdata = 32'hDEADBEEF; e.err = 1'b0;
        c_q.push_back(e);
        c_q.push_back(e);
        c_req = 1'b1; c_we = 1'b0; c_addr = 14'h010;
        for (int j = 1; j <= 8; j++) begin
            @(posedge clk); #1;
            if (c_ack) begin
                if (seen < 2) ackt[seen] = j;
                seen++;
            end
            if (j == 6) c_req = 1'b0;
        end
        check("held_acks", seen, 2);
        check("held_ack1_cyc", ackt[0], 2);
        check("held_ack2_cyc", ackt[1], 5);
        check("held_strobes", strobes - s0, 2);

        // Reset during ACCESS of a CPU write.
        c_req = 1'b1; c_we = 1'b1; c_addr = 14'h020; c_wdata = 32'h00001234;
        @(posedge clk); #1;
        check("rstmid_mem_en_pre", mem_en, 1);
        rst_n = 1'b0;
        #1;
        check("rstmid_mem_en", mem_en, 0);
        check("rstmid_mem_we", mem_we, 0);
        check("rstmid_c_ack", c_ack, 0);
        check("rstmid_err", err, 0);
        check("rstmid_c_rdata", c_rdata, 0);
        c_req = 1'b0; c_we = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int j = 0; j < 4; j++) begin
            @(posedge clk); #1;
            if (c_ack || mem_en) seen++;
        end
        check("rstmid_idle_quiet", seen, 0);
        c_txn(1'b0, 14'h020, 32'h0, 32'h0, 1'b0, lc);
        check("rstmid_new_lat", lc, 2);

        // Loader burst to 0x000..0x003.
        e.rdata = 32'h0; e.err = 1'b0;
        for (int i = 0; i < 4; i++) l_q.push_back(e);
        l_req = 1'b1; l_we = 1'b1; l_addr = 14'h000; l_wdata = 32'hA0;
        t = 0; n = 0;
        while (n < 4 && t < 40) begin
            @(posedge clk); #1; t++;
            if (l_ack) begin
                ackt[n] = t;
                n++;
                @(posedge clk); #1; t++;
                if (n < 4) begin
                    l_addr = AW'(n);
                    l_wdata = 32'hA0 + 32'(n);
                end else begin
                    l_req = 1'b0; l_we = 1'b0;
                end
            end
        end
        l_req = 1'b0; l_we = 1'b0;
        check("burst_count", n, 4);
        check("burst_first", ackt[0], 2);
        for (int i = 1; i < 4; i++) check("burst_spacing", ackt[i] - ackt[i-1], 3);
        for (int i = 0; i < 4; i++) begin
            c_txn(1'b0, AW'(i), 32'h0, 32'hA0 + 32'(i), 1'b0, lc);
        end

        repeat (3) @(posedge clk);
        #1;
        check("c_queue_empty", c_q.size(), 0);
        check("l_queue_empty", l_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
